decode_stage: RTL and testbench

//  Registered, parametrised RV32I decode stage between IF and EX.

---
 rtl/decode_stage.sv | 230 +++++++++++++++++++++++
 tb/tb_decode_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage between IF and EX: combinational decode and register-file read,
// ID/EX output register with valid/ready on both sides, flush, and a one-bubble load-use interlock.
module decode_stage #(
    parameter int PC_W   = 16,
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [31:0]       inst_i,
    input  logic              flush,
    output logic              rs1_re,
    output logic [REG_AW-1:0] rs1_addr,
    input  logic [XLEN-1:0]   rs1_data_i,
    output logic              rs2_re,
    output logic [REG_AW-1:0] rs2_addr,
    input  logic [XLEN-1:0]   rs2_data_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [6:0]        out_opcode,
    output logic [2:0]        out_funct3,
    output logic [6:0]        out_funct7,
    output logic [XLEN-1:0]   out_imm,
    output logic [XLEN-1:0]   out_rs1_data,
    output logic [XLEN-1:0]   out_rs2_data,
    output logic              out_rd_we,
    output logic [REG_AW-1:0] out_rd_addr,
    output logic              out_is_load,
    output logic              out_illegal
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] imm_i(input logic [31:0] w);
        return sext32({{20{w[31]}}, w[31:20]});
    endfunction

    function automatic logic [XLEN-1:0] imm_s(input logic [31:0] w);
        return sext32({{20{w[31]}}, w[31:25], w[11:7]});
    endfunction

    function automatic logic [XLEN-1:0] imm_b(input logic [31:0] w);
        return sext32({{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0});
    endfunction

    function automatic logic [XLEN-1:0] imm_u(input logic [31:0] w);
        return sext32({w[31:12], 12'h000});
    endfunction

    function automatic logic [XLEN-1:0] imm_j(input logic [31:0] w);
        return sext32({{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0});
    endfunction

    logic [6:0]        opcode_s;
    logic [2:0]        funct3_s;
    logic [REG_AW-1:0] rd_field_s;
    logic              rs1_re_s;
    logic              rs2_re_s;
    logic              rd_we_raw_s;
    logic              rd_we_s;
    logic [REG_AW-1:0] rd_addr_s;
    logic              is_load_s;
    logic              illegal_s;
    logic [XLEN-1:0]   imm_val_s;
    logic              hazard_s;
    logic              upd_s;
    logic              acc_s;

    logic              out_valid_r;
    logic [PC_W-1:0]   out_pc_r;
    logic [6:0]        out_opcode_r;
    logic [2:0]        out_funct3_r;
    logic [6:0]        out_funct7_r;
    logic [XLEN-1:0]   out_imm_r;
    logic [XLEN-1:0]   out_rs1_data_r;
    logic [XLEN-1:0]   out_rs2_data_r;
    logic              out_rd_we_r;
    logic [REG_AW-1:0] out_rd_addr_r;
    logic              out_is_load_r;
    logic              out_illegal_r;

    assign opcode_s   = inst_i[6:0];
    assign funct3_s   = inst_i[14:12];
    assign rd_field_s = REG_AW'(inst_i[11:7]);

    // Opcode decode: operand enables, write-back intent and immediate format.
    always_comb begin
        rs1_re_s    = 1'b0;
        rs2_re_s    = 1'b0;
        rd_we_raw_s = 1'b0;
        is_load_s   = 1'b0;
        illegal_s   = 1'b0;
        imm_val_s   = '0;
        case (opcode_s)
            OPC_LUI, OPC_AUIPC: begin
                imm_val_s   = imm_u(inst_i);
                rd_we_raw_s = 1'b1;
            end
            OPC_JAL: begin
                imm_val_s   = imm_j(inst_i);
                rd_we_raw_s = 1'b1;
            end
            OPC_JALR: begin
                imm_val_s   = imm_i(inst_i);
                rs1_re_s    = 1'b1;
                rd_we_raw_s = 1'b1;
            end
            OPC_BRANCH: begin
                imm_val_s = imm_b(inst_i);
                rs1_re_s  = 1'b1;
                rs2_re_s  = 1'b1;
            end
            OPC_STORE: begin
                imm_val_s = imm_s(inst_i);
                rs1_re_s  = 1'b1;
                rs2_re_s  = 1'b1;
            end
            OPC_LOAD: begin
                imm_val_s   = imm_i(inst_i);
                rs1_re_s    = 1'b1;
                rd_we_raw_s = 1'b1;
                is_load_s   = 1'b1;
            end
            OPC_OPIMM: begin
                rs1_re_s    = 1'b1;
                rd_we_raw_s = 1'b1;
                // Shifts carry an unsigned shift amount, not a sign-extended immediate.
                if ((funct3_s == 3'b001) || (funct3_s == 3'b101)) begin
                    imm_val_s = XLEN'(inst_i[24:20]);
                end else begin
                    imm_val_s = imm_i(inst_i);
                end
            end
            OPC_OP: begin
                rs1_re_s    = 1'b1;
                rs2_re_s    = 1'b1;
                rd_we_raw_s = 1'b1;
            end
            OPC_FENCE, OPC_SYSTEM: begin
                illegal_s = 1'b0;
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
    end

    assign rd_we_s   = rd_we_raw_s & (rd_field_s != {REG_AW{1'b0}});
    assign rd_addr_s = rd_we_s ? rd_field_s : {REG_AW{1'b0}};
    assign rs1_re    = rs1_re_s;
    assign rs2_re    = rs2_re_s;
    assign rs1_addr  = rs1_re_s ? REG_AW'(inst_i[19:15]) : {REG_AW{1'b0}};
    assign rs2_addr  = rs2_re_s ? REG_AW'(inst_i[24:20]) : {REG_AW{1'b0}};

    // A held load whose destination feeds this instruction blocks acceptance; once EX
    // takes the load the output slot empties, so exactly one bubble results.
    assign hazard_s = out_valid_r & out_is_load_r & out_rd_we_r &
                      ((rs1_re_s & (rs1_addr == out_rd_addr_r)) |
                       (rs2_re_s & (rs2_addr == out_rd_addr_r)));
    assign upd_s    = ~out_valid_r | out_ready;
    assign in_ready = upd_s & ~hazard_s & ~flush;
    assign acc_s    = in_valid & in_ready;

    // ID/EX register: payload loads only on acceptance; flush clears valid regardless of stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_r    <= 1'b0;
            out_pc_r       <= '0;
            out_opcode_r   <= 7'h00;
            out_funct3_r   <= 3'h0;
            out_funct7_r   <= 7'h00;
            out_imm_r      <= '0;
            out_rs1_data_r <= '0;
            out_rs2_data_r <= '0;
            out_rd_we_r    <= 1'b0;
            out_rd_addr_r  <= '0;
            out_is_load_r  <= 1'b0;
            out_illegal_r  <= 1'b0;
        end else if (upd_s || flush) begin
            out_valid_r <= acc_s & ~flush;
            if (acc_s) begin
                out_pc_r       <= pc_i;
                out_opcode_r   <= opcode_s;
                out_funct3_r   <= funct3_s;
                out_funct7_r   <= inst_i[31:25];
                out_imm_r      <= imm_val_s;
                out_rs1_data_r <= rs1_re_s ? rs1_data_i : {XLEN{1'b0}};
                out_rs2_data_r <= rs2_re_s ? rs2_data_i : {XLEN{1'b0}};
                out_rd_we_r    <= rd_we_s;
                out_rd_addr_r  <= rd_addr_s;
                out_is_load_r  <= is_load_s;
                out_illegal_r  <= illegal_s;
            end
        end
    end

    assign out_valid    = out_valid_r;
    assign out_pc       = out_pc_r;
    assign out_opcode   = out_opcode_r;
    assign out_funct3   = out_funct3_r;
    assign out_funct7   = out_funct7_r;
    assign out_imm      = out_imm_r;
    assign out_rs1_data = out_rs1_data_r;
    assign out_rs2_data = out_rs2_data_r;
    assign out_rd_we    = out_rd_we_r;
    assign out_rd_addr  = out_rd_addr_r;
    assign out_is_load  = out_is_load_r;
    assign out_illegal  = out_illegal_r;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instructions push hand-computed expectations,
// a negedge monitor pops and compares each transfer EX consumes.
module tb_decode_stage;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] pc_i;
    logic [31:0] inst_i;
    logic        flush;
    logic        rs1_re;
    logic [4:0]  rs1_addr;
    logic [31:0] rs1_data_i;
    logic        rs2_re;
    logic [4:0]  rs2_addr;
    logic [31:0] rs2_data_i;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pc;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [31:0] out_imm;
    logic [31:0] out_rs1_data;
    logic [31:0] out_rs2_data;
    logic        out_rd_we;
    logic [4:0]  out_rd_addr;
    logic        out_is_load;
    logic        out_illegal;

    decode_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .pc_i(pc_i), .inst_i(inst_i), .flush(flush),
        .rs1_re(rs1_re), .rs1_addr(rs1_addr), .rs1_data_i(rs1_data_i),
        .rs2_re(rs2_re), .rs2_addr(rs2_addr), .rs2_data_i(rs2_data_i),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_imm(out_imm), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_rd_we(out_rd_we), .out_rd_addr(out_rd_addr), .out_is_load(out_is_load),
        .out_illegal(out_illegal)
    );

    // Register file model: x0 reads 0, rs1 port returns 0x1000_00nn, rs2 port 0x2000_00nn.
    assign rs1_data_i = (rs1_addr == 5'd0) ? 32'h0 : (32'h1000_0000 | {27'h0, rs1_addr});
    assign rs2_data_i = (rs2_addr == 5'd0) ? 32'h0 : (32'h2000_0000 | {27'h0, rs2_addr});

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic        rd_we;
        logic [4:0]  rd;
        logic        ld;
        logic        ill;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %08h, required %08h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] pc, input logic [6:0] opc, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] imm, input logic [31:0] r1,
                                input logic [31:0] r2, input logic we, input logic [4:0] rd,
                                input logic ld, input logic ill);
        exp_t e;
        e = '{pc: pc, opcode: opc, funct3: f3, funct7: f7, imm: imm, rs1d: r1, rs2d: r2,
              rd_we: we, rd: rd, ld: ld, ill: ill};
        return e;
    endfunction

    // Present one instruction, wait (bounded) for acceptance, push its expectation if asked.
    task automatic send(input logic [31:0] inst, input logic [15:0] pc, input exp_t e,
                        input bit push, output int waits);
        in_valid = 1'b1;
        inst_i   = inst;
        pc_i     = pc;
        waits    = 0;
        #1;
        while (!in_ready && waits < 20) begin
            @(posedge clk);
            #1;
            waits++;
        end
        if (!in_ready) begin
            chk("send_timeout", 32'(in_ready), 32'd1);
        end else if (push) begin
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: every transfer taken by EX must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 32'(out_pc), 32'hFFFF_FFFF);
            end else begin
                mon_e = q.pop_front();
                chk("out_pc",       32'(out_pc),       32'(mon_e.pc));
                chk("out_opcode",   32'(out_opcode),   32'(mon_e.opcode));
                chk("out_funct3",   32'(out_funct3),   32'(mon_e.funct3));
                chk("out_funct7",   32'(out_funct7),   32'(mon_e.funct7));
                chk("out_imm",      out_imm,           mon_e.imm);
                chk("out_rs1_data", out_rs1_data,      mon_e.rs1d);
                chk("out_rs2_data", out_rs2_data,      mon_e.rs2d);
                chk("out_rd_we",    32'(out_rd_we),    32'(mon_e.rd_we));
                chk("out_rd_addr",  32'(out_rd_addr),  32'(mon_e.rd));
                chk("out_is_load",  32'(out_is_load),  32'(mon_e.ld));
                chk("out_illegal",  32'(out_illegal),  32'(mon_e.ill));
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 1'b0; inst_i = 32'h0; pc_i = 16'h0; flush = 1'b0; out_ready = 1'b0; rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("reset_out_valid",   32'(out_valid),   32'd0);
        chk("reset_out_imm",     out_imm,          32'd0);
        chk("reset_out_pc",      32'(out_pc),      32'd0);
        chk("reset_out_rd_we",   32'(out_rd_we),   32'd0);
        chk("reset_out_illegal", 32'(out_illegal), 32'd0);
        #20 rst = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // addi x1,x0,-1
        inst_i = 32'hFFF00093; #1;
        chk("addi_rs1_re", 32'(rs1_re), 32'd1);
        chk("addi_rs2_re", 32'(rs2_re), 32'd0);
        send(32'hFFF00093, 16'h0010, mk(16'h0010, 7'h13, 3'h0, 7'h7F, 32'hFFFF_FFFF,
             32'h0, 32'h0, 1'b1, 5'd1, 1'b0, 1'b0), 1'b1, w);
        chk("addi_out_valid", 32'(out_valid), 32'd1);

        // beq x1,x2,-4
        inst_i = 32'hFE208EE3; #1;
        chk("beq_rs1_addr", 32'(rs1_addr), 32'd1);
        chk("beq_rs2_addr", 32'(rs2_addr), 32'd2);
        send(32'hFE208EE3, 16'h0014, mk(16'h0014, 7'h63, 3'h0, 7'h7F, 32'hFFFF_FFFC,
             32'h1000_0001, 32'h2000_0002, 1'b0, 5'd0, 1'b0, 1'b0), 1'b1, w);

        // lw x2,0(x1) then dependent add x3,x2,x1: one bubble
        send(32'h0000A103, 16'h0018, mk(16'h0018, 7'h03, 3'h2, 7'h00, 32'h0,
             32'h1000_0001, 32'h0, 1'b1, 5'd2, 1'b1, 1'b0), 1'b1, w);
        in_valid = 1'b1; inst_i = 32'h001101B3; pc_i = 16'h001C; #1;
        chk("load_use_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("load_use_bubble", 32'(out_valid), 32'd0);
        chk("load_use_release", 32'(in_ready), 32'd1);
        send(32'h001101B3, 16'h001C, mk(16'h001C, 7'h33, 3'h0, 7'h00, 32'h0,
             32'h1000_0002, 32'h2000_0001, 1'b1, 5'd3, 1'b0, 1'b0), 1'b1, w);
        chk("add_wait_cycles", 32'(w), 32'd0);
        @(posedge clk); #1;

        // srai x5,x1,3 held for three stalled cycles
        out_ready = 1'b0;
        send(32'h4030D293, 16'h0020, mk(16'h0020, 7'h13, 3'h5, 7'h20, 32'h3,
             32'h1000_0001, 32'h0, 1'b1, 5'd5, 1'b0, 1'b0), 1'b1, w);
        for (int i = 0; i < 3; i++) begin
            chk("stall_out_valid", 32'(out_valid),   32'd1);
            chk("stall_out_imm",   out_imm,          32'h3);
            chk("stall_out_pc",    32'(out_pc),      32'h0020);
            chk("stall_out_rd",    32'(out_rd_addr), 32'd5);
            chk("stall_in_ready",  32'(in_ready),    32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;

        // lui x7 / auipc x3 / sw x2,-8(x1) / jal x0,+4096 / fence, back to back
        send(32'hABCDE3B7, 16'h0024, mk(16'h0024, 7'h37, 3'h6, 7'h55, 32'hABCD_E000,
             32'h0, 32'h0, 1'b1, 5'd7, 1'b0, 1'b0), 1'b1, w);
        send(32'hFFFFF197, 16'h0028, mk(16'h0028, 7'h17, 3'h7, 7'h7F, 32'hFFFF_F000,
             32'h0, 32'h0, 1'b1, 5'd3, 1'b0, 1'b0), 1'b1, w);
        send(32'hFE20AC23, 16'h002C, mk(16'h002C, 7'h23, 3'h2, 7'h7F, 32'hFFFF_FFF8,
             32'h1000_0001, 32'h2000_0002, 1'b0, 5'd0, 1'b0, 1'b0), 1'b1, w);
        send(32'h0000106F, 16'h0030, mk(16'h0030, 7'h6F, 3'h1, 7'h00, 32'h0000_1000,
             32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0), 1'b1, w);
        send(32'h0FF0000F, 16'h0034, mk(16'h0034, 7'h0F, 3'h0, 7'h07, 32'h0,
             32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0), 1'b1, w);

        // Unknown opcode 0x7F
        inst_i = 32'hFFFFFFFF; #1;
        chk("illegal_rs1_re", 32'(rs1_re), 32'd0);
        chk("illegal_rs2_re", 32'(rs2_re), 32'd0);
        send(32'hFFFFFFFF, 16'h0038, mk(16'h0038, 7'h7F, 3'h7, 7'h7F, 32'h0,
             32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b1), 1'b1, w);
        @(posedge clk); #1;

        // Flush with an instruction offered: nothing accepted
        in_valid = 1'b1; inst_i = 32'hFFF00093; pc_i = 16'h0040; flush = 1'b1; #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);

        // Flush kills a stalled held instruction
        out_ready = 1'b0;
        send(32'hABCDE3B7, 16'h0044, mk(16'h0, 7'h0, 3'h0, 7'h0, 32'h0, 32'h0, 32'h0,
             1'b0, 5'd0, 1'b0, 1'b0), 1'b0, w);
        chk("held_before_flush", 32'(out_valid), 32'd1);
        flush = 1'b1; #1;
        chk("flush_held_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_held_out_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset with an instruction held
        send(32'hFFFFF197, 16'h0048, mk(16'h0, 7'h0, 3'h0, 7'h0, 32'h0, 32'h0, 32'h0,
             1'b0, 5'd0, 1'b0, 1'b0), 1'b0, w);
        chk("held_before_reset", 32'(out_valid), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid),   32'd0);
        chk("async_rst_out_imm",   out_imm,          32'd0);
        chk("async_rst_out_pc",    32'(out_pc),      32'd0);
        chk("async_rst_out_rd_we", 32'(out_rd_we),   32'd0);
        #3 rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
